// File: rtl/uart_receiver.sv
// Serial 8N1 receiver with a one-byte holding register, tri-stated onto the CPU data bus.
// Latency: rx_ready rises 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT edges after the rx falling edge.
// Backpressure: none on the line side; an unread byte blocks the next one, which sets overrun.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_n,
    output logic [7:0] data,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: the start bit is checked half a bit in, later bits one full bit apart.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    logic          sync_1;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [7:0]    hold_q;

    logic bit_end;
    logic stop_sample;
    logic stop_good;
    logic stop_bad;
    logic rd_cycle;
    logic load;
    logic lost;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_1 <= rx;
            rxs    <= sync_1;
        end
    end

    assign bit_end     = (cnt == CNT_LAST);
    assign stop_sample = (state == ST_STOP) && bit_end;
    assign stop_good   = stop_sample && rxs;
    assign stop_bad    = stop_sample && !rxs;
    assign rd_cycle    = !rd_n;

    // A read on the stop edge frees the holding register, so the arriving byte is not lost.
    assign load = stop_good && (!rx_ready || rd_cycle);
    assign lost = stop_good && rx_ready && !rd_cycle;

    // Frame sequencer: start qualification, mid-bit data sampling, stop check and break wait.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        // Still low at mid start bit: a real frame. High again: a glitch.
                        if (!rxs) begin
                            state <= ST_DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= '0;
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rxs ? ST_IDLE : ST_BRK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BRK: begin
                    // A held-low line must return high before another start bit is accepted.
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register and status flags; a new event on the same edge beats the read-clear.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            hold_q    <= 8'h00;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load) begin
                hold_q <= shreg;
            end

            if (load) begin
                rx_ready <= 1'b1;
            end else if (rd_cycle) begin
                rx_ready <= 1'b0;
            end

            if (lost) begin
                overrun <= 1'b1;
            end else if (rd_cycle) begin
                overrun <= 1'b0;
            end

            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (rd_cycle) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Bus drive is purely combinational from rd_n so data settles before the CPU's latch edge.
    assign data = rd_n ? 8'hzz : hold_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       rd_n   = 1'b1;
    wire  [7:0] data;
    logic       rx_ready;
    logic       overrun;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic       pre_rdy;
    logic       post_rdy;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk     (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_n      (rd_n),
        .data      (data),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Pop the next expected byte from the scoreboard and compare it with the bus.
    task automatic expect_data(input string tag);
        logic [7:0] exp;
        n_checks++;
        assert (sb.size() > 0)
        else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected a pending byte", tag);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        check(tag, data, exp);
    endtask

    // One read cycle: bus checked before the edge, rx_ready checked after it.
    task automatic do_read(input string tag);
        rd_n = 1'b0;
        #1;
        expect_data(tag);
        step(1);
        rd_n = 1'b1;
        check({tag, "_rdy_clr"}, {7'd0, rx_ready}, 8'd0);
    endtask

    // Drive one 8N1 frame. Stop sample lands on the 11th edge of the stop bit;
    // rx_ready is captured two edges before and one edge after that point.
    task automatic send(input logic [7:0] b, input logic stop_bit, input bit rd_at_stop);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB / 2 + 1);
        pre_rdy = rx_ready;
        step(1);
        if (rd_at_stop) begin
            rd_n = 1'b0;
            #1;
            expect_data("stop_edge_rd");
        end
        step(1);
        rd_n = 1'b1;
        step(1);
        post_rdy = rx_ready;
        step(CPB - CPB / 2 - 4);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_rdy", {7'd0, rx_ready}, 8'd0);
        check("rst_ovr", {7'd0, overrun}, 8'd0);
        check("rst_ferr", {7'd0, frame_err}, 8'd0);
        rd_n = 1'b0;
        #1;
        check("rst_data", data, 8'h00);
        rd_n = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);

        // 1: basic frame and latency
        sb.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        check("t1_pre_rdy", {7'd0, pre_rdy}, 8'd0);
        check("t1_post_rdy", {7'd0, post_rdy}, 8'd1);
        check("t1_ferr", {7'd0, frame_err}, 8'd0);
        check("t1_ovr", {7'd0, overrun}, 8'd0);
        do_read("t1_data");
        check("t1_ovr_after", {7'd0, overrun}, 8'd0);
        step(5);

        // 2: false start glitch, then a good frame
        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(30);
        check("t2_glitch_rdy", {7'd0, rx_ready}, 8'd0);
        check("t2_glitch_ferr", {7'd0, frame_err}, 8'd0);
        sb.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0);
        check("t2_rdy", {7'd0, rx_ready}, 8'd1);
        do_read("t2_data");
        step(5);

        // 3: overrun, first byte kept
        sb.push_back(8'h11);
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        check("t3_rdy", {7'd0, rx_ready}, 8'd1);
        check("t3_ovr", {7'd0, overrun}, 8'd1);
        do_read("t3_data");
        check("t3_ovr_clr", {7'd0, overrun}, 8'd0);
        step(5);

        // 4: framing error, held break, recovery
        send(8'h55, 1'b0, 1'b0);
        check("t4_ferr", {7'd0, frame_err}, 8'd1);
        check("t4_rdy", {7'd0, rx_ready}, 8'd0);
        step(40);
        check("t4_brk_rdy", {7'd0, rx_ready}, 8'd0);
        rx = 1'b1;
        step(5);
        sb.push_back(8'h0F);
        send(8'h0F, 1'b1, 1'b0);
        check("t4_rdy2", {7'd0, rx_ready}, 8'd1);
        check("t4_ferr_sticky", {7'd0, frame_err}, 8'd1);
        do_read("t4_data");
        check("t4_ferr_clr", {7'd0, frame_err}, 8'd0);
        step(5);

        // 5: async reset mid-frame with flags set
        send(8'h99, 1'b1, 1'b0);
        send(8'h98, 1'b1, 1'b0);
        check("t5_pre_rdy", {7'd0, rx_ready}, 8'd1);
        check("t5_pre_ovr", {7'd0, overrun}, 8'd1);
        rx = 1'b0;
        step(CPB);
        rx = 1'b1;
        step(3 * CPB);
        reset = 1'b1;
        #1;
        check("t5_rst_rdy", {7'd0, rx_ready}, 8'd0);
        check("t5_rst_ovr", {7'd0, overrun}, 8'd0);
        check("t5_rst_ferr", {7'd0, frame_err}, 8'd0);
        rd_n = 1'b0;
        #1;
        check("t5_rst_data", data, 8'h00);
        rd_n = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);
        sb.push_back(8'h81);
        send(8'h81, 1'b1, 1'b0);
        check("t5_rdy", {7'd0, rx_ready}, 8'd1);
        do_read("t5_data");
        step(5);

        // 6: read on the exact stop-sample edge with a byte pending
        sb.push_back(8'h12);
        send(8'h12, 1'b1, 1'b0);
        check("t6_pend", {7'd0, rx_ready}, 8'd1);
        sb.push_back(8'h77);
        send(8'h77, 1'b1, 1'b1);
        check("t6_rdy", {7'd0, rx_ready}, 8'd1);
        check("t6_ovr", {7'd0, overrun}, 8'd0);
        do_read("t6_data");

        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
